instr_fetch_queue: RTL
======================

Name: instr_fetch_queue

Overview:
Fetch stage directly upstream of the instruction memory in the RV32I core. Owns the fetch PC, drives the byte address into the instruction memory (combinational read, same-cycle data), and captures {pc, instr} pairs into a small FIFO. Decode pops entries with a valid/ready handshake. A redirect from execute (branch/jump) flushes the queue and reloads the PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC value loaded on reset
DEPTH, 2, queue entries; power of two, >= 2
ADDR_WIDTH, 32, width of PC and memory address

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  ADDR_WIDTH  byte address to instruction memory; always equals fetch_pc
imem_instr  input  32  instruction word returned combinationally for imem_addr
redirect_valid  input  1  load redirect_pc and flush queue
redirect_pc  input  ADDR_WIDTH  redirect target
out_valid  output  1  queue head holds a valid entry
out_ready  input  1  decode accepts head this cycle
out_instr  output  32  head instruction
out_pc  output  ADDR_WIDTH  PC of head instruction
out_misaligned  output  1  only with FETCH_MISALIGN_CHECK_EN; sticky misaligned-redirect flag

Behaviour:
- Reset (async assert, any time incl. mid-operation): fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0; out_valid=0, out_instr=0, out_pc=0 (entry storage cleared), out_misaligned=0.
- pop = out_valid & out_ready. push = !redirect_valid & (count<DEPTH | pop) [& !halted with feature].
- push: entry[wr_ptr]={fetch_pc, imem_instr}; wr_ptr++ mod DEPTH; fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0, carry discarded).
- pop: rd_ptr++ mod DEPTH. count updates by push-pop; simultaneous push and pop at full or empty-with-entry legal, count unchanged.
- No push when full and no pop: fetch_pc held, imem_addr stable.
- out_valid = (count!=0); out_instr/out_pc = entry[rd_ptr]; outputs are register-sourced, no combinational path from imem_instr or redirect to out_*.
- Latency: entry appears at out_* the cycle after its address is presented; first out_valid in the cycle after first clk edge following reset release. Steady state with out_ready=1: one instruction per cycle.
- Redirect (highest priority): next edge: rd_ptr=wr_ptr=0, count=0, fetch_pc=redirect_pc (low 2 bits forced 0 without feature), no push. A pop in the same cycle still completes for decode; remaining entries discarded. out_valid=0 the cycle after redirect, valid again one cycle later with out_pc=redirect target.
- Back-to-back redirects: each overrides; last one wins.
- out_ready while out_valid=0: ignored.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined: out_misaligned port exists. Redirect with redirect_pc[1:0]!=0 loads fetch_pc=redirect_pc & ~3, sets out_misaligned=1, enters halted state (no push) until a redirect with aligned target clears flag and halt. Aligned redirect always clears.
- Undefined: port absent; redirect_pc[1:0] ignored, no halt state.

Test Plan:
- Reset RESET_PC=0, memory word i = 32'h1000_0000+i, out_ready=1 -> out_pc 0,4,8,C... one per cycle, out_instr 1000_0000,1000_0001,...
- out_ready=0 for 5 cycles after reset -> count saturates at 2, out_pc held 0, imem_addr held 8; release -> pops 0,4,8 consecutive, no gaps/duplicates.
- redirect_valid with redirect_pc=0x40 while queue full, out_ready=1 same cycle -> head 0x0 consumed, next cycle out_valid=0, following cycle out_pc=0x40, then 0x44.
- fetch_pc driven to 0xFFFF_FFFC via redirect -> next out_pc 0xFFFF_FFFC then 0x0000_0000.
- Assert rst asynchronously mid-stream with full queue -> out_valid=0 and imem_addr=RESET_PC immediately, before next clk edge.
- (Feature) redirect_pc=0x42 -> out_misaligned=1, imem_addr=0x40, out_valid stays 0; redirect_pc=0x80 -> flag clears, out_pc=0x80 two cycles later.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, reads instruction memory and queues {pc, instr} for decode.
// Optional misaligned-redirect detection and halt is enabled by defining FETCH_MISALIGN_CHECK_EN.
module instr_fetch_queue #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                  out_misaligned
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0] ent_pc_q    [DEPTH];
    logic [ADDR_WIDTH-1:0] ent_pc_d    [DEPTH];
    logic [31:0]           ent_instr_q [DEPTH];
    logic [31:0]           ent_instr_d [DEPTH];

    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  halted;
    logic [ADDR_WIDTH-1:0] redirect_aligned;

    // Low two bits of the target are dropped: instructions are word aligned.
    assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    assign halted         = misaligned_q;
    assign out_misaligned = misaligned_q;

    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect_valid) begin
            misaligned_d = |redirect_pc[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign halted              = 1'b0;
`endif

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = ent_pc_q[rd_ptr_q];
    assign out_instr = ent_instr_q[rd_ptr_q];

    assign full = (count_q == CntW'(DEPTH));
    assign pop  = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign push = ~redirect_valid & (~full | pop) & ~halted;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                ent_pc_d[wr_ptr_q]    = fetch_pc_q;
                ent_instr_d[wr_ptr_q] = imem_instr;
                wr_ptr_d              = wr_ptr_q + PtrW'(1);
                fetch_pc_d            = fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_pc_q[i]    <= '0;
                ent_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ent_pc_q    <= ent_pc_d;
            ent_instr_q <= ent_instr_d;
        end
    end

endmodule
